// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: CPU-side write port of the buffered UART transmitter.
//   wr_data / wr_en : byte and write strobe (CPU -> transmitter)
//   full / level    : FIFO occupancy status (transmitter -> CPU)
//   busy            : transmitter activity (transmitter -> CPU)
// DEPTH must match the DEPTH of the uart_tx_fifo it connects to.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
) ();
  logic [7:0]              wr_data;
  logic                    wr_en;
  logic                    full;
  logic [$clog2(DEPTH):0]  level;
  logic                    busy;

  modport master (
    output wr_data,
    output wr_en,
    input  full,
    input  level,
    input  busy
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    output full,
    output level,
    output busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes written through the bus interface are queued in a DEPTH-entry FIFO
// and serialized LSB first onto uart_tx_out at CLK_HZ/BAUD cycles per bit.
// Ports:
//   clk_48mhz   : the only clock, rising edge
//   reset       : synchronous, active-high; flushes FIFO and abandons frame
//   bus         : write port (wr_data, wr_en) and status (full, level, busy)
//   uart_tx_out : registered serial line, idles high
module uart_tx_fifo #(
  parameter int CLK_HZ = 48000000,
  parameter int BAUD   = 115200,
  parameter int DEPTH  = 16
) (
  input  logic            clk_48mhz,
  input  logic            reset,
  uart_tx_fifo_if.slave   bus,
  output logic            uart_tx_out
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_d;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          wr_acc;
  logic          pop;

  assign full     = (level == (AW+1)'(DEPTH));
  assign wr_acc   = bus.wr_en && !full;
  assign bus.full  = full;
  assign bus.level = level;
  assign bus.busy  = (state != IDLE) || (level != '0);

  // FIFO storage; contents are not reset.
  always_ff @(posedge clk_48mhz) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_acc, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Pop decisions use the registered level, so a write landing on the last
  // stop-bit cycle is only seen one cycle later from IDLE.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          cnt_n   = DIV_M1;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          cnt_n   = DIV_M1;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n   = DIV_M1;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (level != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            cnt_n   = DIV_M1;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line value is derived from the next state so the register changes on the
  // same edge as the state transition.
  always_comb begin
    tx_d = 1'b1;
    case (state_n)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_n[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      uart_tx_out <= 1'b1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      shift       <= shift_n;
      uart_tx_out <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 100000;
  localparam int DEPTH  = 16;
  localparam int FRAME  = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         n_starts = 0;
  int         n_rx = 0;
  bit         rx_act = 1'b0;
  int         rx_ph = 0;
  logic [7:0] rx_b = '0;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .DEPTH (DEPTH)
  ) dut (
    .clk_48mhz  (clk),
    .reset      (rst),
    .bus        (bus.slave),
    .uart_tx_out(tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy !== 1'b0 || rx_act) && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  // Receiver model: samples mid-bit on the falling clock edge.
  always @(negedge clk) begin
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_ph  = 0;
        n_starts++;
        start_q.push_back(cyc);
      end
    end else begin
      rx_ph++;
      if (rx_ph == 5) begin
        check("rx_start_bit", 32'(tx), 32'd0);
      end else if (rx_ph >= 15 && rx_ph <= 85 && (rx_ph % 10) == 5) begin
        rx_b = {tx, rx_b[7:1]};
      end else if (rx_ph == 95) begin
        check("rx_stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL rx_unexpected: observed %0h expected no frame", rx_b);
        end else begin
          check("rx_byte", 32'(rx_b), 32'(exp_q.pop_front()));
        end
        n_rx++;
        rx_act = 1'b0;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int s0;
    int ns;
    bit full_seen;

    bus.wr_en   = 1'b0;
    bus.wr_data = '0;

    // 1. Reset
    rst = 1'b1;
    ticks(3);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    tick();

    // 2. Single byte 0xA5
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5; exp_q.push_back(8'hA5);
    s0 = start_q.size();
    tick();
    e0 = cyc;
    bus.wr_en = 1'b0;
    check("single_level_e0", 32'(bus.level), 32'd1);
    check("single_busy_e0", 32'(bus.busy), 32'd1);
    check("single_tx_e0", 32'(tx), 32'd1);
    tick();
    check("single_tx_e1", 32'(tx), 32'd0);
    check("single_level_e1", 32'(bus.level), 32'd0);
    ticks(FRAME - 1);
    check("single_tx_last_stop", 32'(tx), 32'd1);
    check("single_busy_last_stop", 32'(bus.busy), 32'd1);
    tick();
    check("single_busy_drop", 32'(bus.busy), 32'd0);
    wait_idle(50);
    check("single_start_cycle", 32'(start_q[s0]), 32'(e0 + 1));
    check("single_rx_done", 32'(exp_q.size()), 32'd0);

    // 3. Back-to-back frames
    s0 = start_q.size();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h00; exp_q.push_back(8'h00); tick();
    bus.wr_data = 8'hFF; exp_q.push_back(8'hFF); tick();
    bus.wr_data = 8'h55; exp_q.push_back(8'h55); tick();
    bus.wr_en = 1'b0;
    wait_idle(400);
    check("b2b_frames", 32'(start_q.size() - s0), 32'd3);
    check("b2b_gap1", 32'(start_q[s0+1] - start_q[s0]), 32'(FRAME));
    check("b2b_gap2", 32'(start_q[s0+2] - start_q[s0+1]), 32'(FRAME));
    check("b2b_rx_done", 32'(exp_q.size()), 32'd0);

    // 4. Full / overflow: 18 writes, 0x12 dropped
    for (int i = 1; i <= 18; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      if (i <= 17) exp_q.push_back(8'(i));
      tick();
      if (i == 16) check("ovf_not_full_15", 32'(bus.full), 32'd0);
      if (i == 17) check("ovf_full_16", 32'(bus.full), 32'd1);
    end
    bus.wr_en = 1'b0;
    check("ovf_level_after_drop", 32'(bus.level), 32'd16);
    check("ovf_full_after_drop", 32'(bus.full), 32'd1);
    wait_idle(2200);
    check("ovf_rx_done", 32'(exp_q.size()), 32'd0);

    // 5. Simultaneous write and pop at end of stop bit
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h31; exp_q.push_back(8'h31); tick();
    e0 = cyc;
    bus.wr_data = 8'h32; exp_q.push_back(8'h32); tick();
    bus.wr_data = 8'h33; exp_q.push_back(8'h33); tick();
    bus.wr_data = 8'h34; exp_q.push_back(8'h34); tick();
    bus.wr_en = 1'b0;
    while (cyc < e0 + FRAME) tick();
    check("simul_level_before", 32'(bus.level), 32'd3);
    bus.wr_en = 1'b1; bus.wr_data = 8'h35; exp_q.push_back(8'h35);
    tick();
    bus.wr_en = 1'b0;
    check("simul_level_after", 32'(bus.level), 32'd3);
    check("simul_tx_start", 32'(tx), 32'd0);
    wait_idle(700);
    check("simul_rx_done", 32'(exp_q.size()), 32'd0);

    // 6. Pointer wrap: 40 bytes, level kept below DEPTH
    full_seen = 1'b0;
    s0 = n_rx;
    for (int i = 0; i < 40; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h80 + i);
      exp_q.push_back(8'(8'h80 + i));
      tick();
      bus.wr_en = 1'b0;
      for (int k = 0; k < 79; k++) begin
        if (bus.full) full_seen = 1'b1;
        tick();
      end
    end
    wait_idle(1500);
    check("wrap_never_full", 32'(full_seen), 32'd0);
    check("wrap_rx_count", 32'(n_rx - s0), 32'd40);
    check("wrap_rx_done", 32'(exp_q.size()), 32'd0);

    // 1b. Reset mid-frame during bit 3
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hC3; exp_q.push_back(8'hC3); tick();
    e0 = cyc - 1;
    bus.wr_data = 8'h3C; exp_q.push_back(8'h3C); tick();
    bus.wr_en = 1'b0;
    while (cyc < e0 + 1 + 45) tick();
    check("mid_level_before", 32'(bus.level), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_level", 32'(bus.level), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    ns = n_starts;
    ticks(150);
    check("mid_no_frame", 32'(n_starts), 32'(ns));
    check("mid_tx_idle", 32'(tx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
